uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, data width of a received frame.
REQ-002 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on it.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_en  input  1  level; 1 = receiver enabled.
REQ-006 SHALL have port cfg_load_value  input  10  baud reload value requested.
REQ-007 SHALL have port err_clr  input  1  one-cycle pulse clearing sticky error flags.
REQ-008 SHALL have port rx_done, rx_busy, rx_err  input  1 each  status from the receive datapath.
REQ-009 SHALL have port rx_data  input  N  frame data from the receive datapath.
REQ-010 SHALL have port rx_en, rx_rst  output  1 each  datapath enable and sync reset.
REQ-011 SHALL have port load_value  output  10  registered reload value to the datapath.
REQ-012 SHALL have port rd_en  input  1  consumer pop strobe.
REQ-013 SHALL have port rd_data  output  N  FIFO head (show-ahead).
REQ-014 SHALL have port empty, full, overrun, frame_err, irq  output  1 each  status.

Function
REQ-015 FSM states SHALL be IDLE, ARM, RECV, ERR, DRAIN.
REQ-016 IDLE: rx_en=0; cfg_en=1 -> ARM next cycle.
REQ-017 ARM (exactly one cycle): load_value<=cfg_load_value, rx_rst=1, rx_en=0; -> RECV.
REQ-018 RECV: rx_en=1, rx_rst=0; rx_done&!rx_err pushes rx_data in the same cycle.
REQ-019 RECV, rx_done&rx_err: no push, frame_err<=1, -> ERR.
REQ-020 ERR (exactly one cycle): rx_rst=1, rx_en=0; -> RECV if cfg_en else IDLE.
REQ-021 RECV, cfg_en=0: rx_busy=0 -> IDLE; rx_busy=1 -> DRAIN.
REQ-022 DRAIN: rx_en=1; on rx_done (processed per REQ-018/019 push/flag rules) -> IDLE; cfg_en re-asserted does not abort DRAIN.
REQ-023 load_value SHALL change only in ARM; cfg_load_value changes elsewhere are ignored until next ARM.
REQ-024 FIFO push when full and no pop in same cycle: data dropped, overrun<=1.
REQ-025 Push and pop in same cycle when full: both occur, no overrun; when empty: push occurs, pop ignored.
REQ-026 Pop when empty SHALL be ignored; rd_data undefined-but-stable (holds last RAM value).
REQ-027 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; empty = pointers equal, full = MSB differ, rest equal.
REQ-028 empty/full SHALL be combinational from pointers; update cycle after push/pop.
REQ-029 overrun, frame_err sticky until err_clr; err_clr coincident with a new set event leaves flag set.
REQ-030 FIFO contents SHALL survive IDLE/ERR transitions; only arst_n clears them.

Reset
REQ-031 arst_n=0 SHALL force state IDLE, pointers 0, load_value 0, overrun/frame_err/irq 0, rx_en 0, rx_rst 0, empty 1, full 0.
REQ-032 arst_n mid-frame SHALL abandon the frame; no push after release until a new ARM.
REQ-033 Release SHALL be synchronous-deassert-safe: first active edge after release evaluates IDLE.

Configuration
REQ-034 Macro UART_RX_CTRL_IRQ_EN defined: irq registered = !empty | overrun | frame_err, asserted cycle after cause.
REQ-035 Macro undefined: irq tied 0, no irq logic synthesised; all other behaviour identical.

Structure
REQ-036 Shared package SHALL hold the FSM state enum (3-bit encoding) and the 10-bit load-value width constant.
REQ-037 FIFO SHALL be sub-module uart_rx_fifo (N, DEPTH); FSM and flags in uart_rx_ctrl.

Verification
REQ-038 Reset, cfg_en=1, cfg_load_value=10'd325 -> ARM 1 cycle with rx_rst=1, load_value=325, then rx_en=1.
REQ-039 Five rx_done pulses data 0x11..0x15, DEPTH=4, no pops -> FIFO holds 0x11..0x14, full=1, overrun=1; err_clr -> overrun=0.
REQ-040 rx_done with rx_err=1 -> no push, frame_err=1, one-cycle rx_rst, back to RECV; irq=1 only with macro defined.
REQ-041 Full FIFO, simultaneous rx_done(0xA5) and rd_en -> rd_data advances, 0xA5 stored, overrun stays 0.
REQ-042 cfg_en dropped while rx_busy=1 -> DRAIN, final frame pushed on rx_done, then IDLE with rx_en=0.
REQ-043 arst_n pulsed in RECV with 2 entries stored -> empty=1, state IDLE, all flags 0.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_rx_ctrl_pkg;

  localparam int LOAD_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RECV  = 3'd2,
    ERR   = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Controller <-> receive datapath handshake: master = controller, slave = datapath.
interface uart_rx_ctrl_if
  import uart_rx_ctrl_pkg::*;
#(
  parameter int N = 8
);
  logic              rx_en;
  logic              rx_rst;
  logic [LOAD_W-1:0] load_value;
  logic              rx_done;
  logic              rx_busy;
  logic              rx_err;
  logic [N-1:0]      rx_data;

  modport master (
    output rx_en, rx_rst, load_value,
    input  rx_done, rx_busy, rx_err, rx_data
  );

  modport slave (
    input  rx_en, rx_rst, load_value,
    output rx_done, rx_busy, rx_err, rx_data
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic [N-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot on the same edge, so a push into a full FIFO is accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences the datapath, buffers frames, keeps sticky errors.
// Define UART_RX_CTRL_IRQ_EN to build the registered interrupt output.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cfg_en,
  input  logic [LOAD_W-1:0] cfg_load_value,
  input  logic              err_clr,
  uart_rx_ctrl_if.master    rx_if,
  input  logic              rd_en,
  output logic [N-1:0]      rd_data,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              frame_err,
  output logic              irq
);
  state_t            state;
  logic              rx_en_q;
  logic              rx_rst_q;
  logic [LOAD_W-1:0] load_value_q;
  logic              rx_active;
  logic              push;
  logic              frame_bad;
  logic              fifo_empty;
  logic              fifo_full;

  assign rx_if.rx_en      = rx_en_q;
  assign rx_if.rx_rst     = rx_rst_q;
  assign rx_if.load_value = load_value_q;

  assign rx_active = (state == RECV) || (state == DRAIN);
  assign push      = rx_active && rx_if.rx_done && !rx_if.rx_err;
  assign frame_bad = rx_active && rx_if.rx_done && rx_if.rx_err;

  assign empty = fifo_empty;
  assign full  = fifo_full;

  uart_rx_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (push),
    .push_data (rx_if.rx_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs are registered alongside the transition, so they track the state being entered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      rx_en_q      <= 1'b0;
      rx_rst_q     <= 1'b0;
      load_value_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          rx_en_q <= 1'b0;
          if (cfg_en) begin
            state        <= ARM;
            rx_rst_q     <= 1'b1;
            load_value_q <= cfg_load_value;
          end else begin
            rx_rst_q <= 1'b0;
          end
        end
        ARM: begin
          state    <= RECV;
          rx_en_q  <= 1'b1;
          rx_rst_q <= 1'b0;
        end
        RECV: begin
          if (frame_bad) begin
            state    <= ERR;
            rx_en_q  <= 1'b0;
            rx_rst_q <= 1'b1;
          end else if (!cfg_en) begin
            if (rx_if.rx_busy) begin
              state <= DRAIN;
            end else begin
              state   <= IDLE;
              rx_en_q <= 1'b0;
            end
          end
        end
        ERR: begin
          rx_rst_q <= 1'b0;
          if (cfg_en) begin
            state   <= RECV;
            rx_en_q <= 1'b1;
          end else begin
            state   <= IDLE;
            rx_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (rx_if.rx_done) begin
            state   <= IDLE;
            rx_en_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rx_en_q  <= 1'b0;
          rx_rst_q <= 1'b0;
        end
      endcase
    end
  end

  // Set events win over a coincident clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && fifo_full && !rd_en) overrun <= 1'b1;
      else if (err_clr)                overrun <= 1'b0;
      if (frame_bad)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) irq <= 1'b0;
    else         irq <= !fifo_empty || overrun || frame_err;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (N=8, DEPTH=4) with immediate-assertion checks.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

`ifdef UART_RX_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n;
  logic       cfg_en;
  logic [9:0] cfg_load_value;
  logic       err_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overrun, frame_err, irq;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  uart_rx_ctrl_if #(.N(8)) rx_if ();

  uart_rx_ctrl #(.N(8), .DEPTH(4)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .cfg_en         (cfg_en),
    .cfg_load_value (cfg_load_value),
    .err_clr        (err_clr),
    .rx_if          (rx_if),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .overrun        (overrun),
    .frame_err      (frame_err),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; cfg_en = 1'b0; cfg_load_value = '0; err_clr = 1'b0; rd_en = 1'b0;
    rx_if.rx_done = 1'b0; rx_if.rx_busy = 1'b0; rx_if.rx_err = 1'b0; rx_if.rx_data = '0;
    tick(); tick();
    chk("rst_rx_en", 32'(rx_if.rx_en), 0);
    chk("rst_rx_rst", 32'(rx_if.rx_rst), 0);
    chk("rst_load", 32'(rx_if.load_value), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", {29'd0, overrun, frame_err, irq}, 0);
    arst_n = 1'b1;
    tick();
    chk("idle_rx_en", 32'(rx_if.rx_en), 0);

    // Arm with reload 325
    cfg_en = 1'b1; cfg_load_value = 10'd325;
    tick();
    chk("arm_rx_rst", 32'(rx_if.rx_rst), 1);
    chk("arm_rx_en", 32'(rx_if.rx_en), 0);
    chk("arm_load", 32'(rx_if.load_value), 325);
    cfg_load_value = 10'd7;
    tick();
    chk("recv_rx_en", 32'(rx_if.rx_en), 1);
    chk("recv_rx_rst", 32'(rx_if.rx_rst), 0);
    tick();
    chk("load_held", 32'(rx_if.load_value), 325);

    // Five frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      rx_if.rx_data = 8'h11 + 8'(i);
      rx_if.rx_done = 1'b1;
      tick();
      if (i == 3) begin
        chk("fill_full", 32'(full), 1);
        chk("fill_no_ovr", 32'(overrun), 0);
      end
    end
    rx_if.rx_done = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_full", 32'(full), 1);
    chk("ovr_head", 32'(rd_data), 32'h11);
    tick();
    chk("irq_fifo", 32'(irq), 32'(IRQ_ON));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);

    // Push and pop together while full
    rx_if.rx_data = 8'hA5; rx_if.rx_done = 1'b1; rd_en = 1'b1;
    tick();
    rx_if.rx_done = 1'b0; rd_en = 1'b0;
    chk("pp_head", 32'(rd_data), 32'h12);
    chk("pp_full", 32'(full), 1);
    chk("pp_no_ovr", 32'(overrun), 0);
    rd_en = 1'b1;
    tick(); chk("pop_13", 32'(rd_data), 32'h13);
    tick(); chk("pop_14", 32'(rd_data), 32'h14);
    tick(); chk("pop_a5", 32'(rd_data), 32'hA5);
    chk("pop_not_empty", 32'(empty), 0);
    tick(); chk("pop_empty", 32'(empty), 1);
    tick();
    rd_en = 1'b0;
    chk("pop_empty_ign", {30'd0, empty, full}, 32'b10);

    // Framing error
    rx_if.rx_done = 1'b1; rx_if.rx_err = 1'b1;
    tick();
    rx_if.rx_done = 1'b0; rx_if.rx_err = 1'b0;
    chk("ferr_set", 32'(frame_err), 1);
    chk("ferr_rx_rst", 32'(rx_if.rx_rst), 1);
    chk("ferr_rx_en", 32'(rx_if.rx_en), 0);
    chk("ferr_no_push", 32'(empty), 1);
    tick();
    chk("ferr_back_recv", {30'd0, rx_if.rx_en, rx_if.rx_rst}, 32'b10);
    chk("irq_ferr", 32'(irq), 32'(IRQ_ON));
    rx_if.rx_done = 1'b1; rx_if.rx_err = 1'b1; err_clr = 1'b1;
    tick();
    rx_if.rx_done = 1'b0; rx_if.rx_err = 1'b0; err_clr = 1'b0;
    chk("ferr_set_wins", 32'(frame_err), 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ferr_clr", 32'(frame_err), 0);
    tick();
    chk("irq_quiet", 32'(irq), 0);

    // Drain on disable while busy
    rx_if.rx_busy = 1'b1; cfg_en = 1'b0;
    tick();
    chk("drain_state", 32'(dut.state), 32'(DRAIN));
    chk("drain_rx_en", 32'(rx_if.rx_en), 1);
    cfg_en = 1'b1;
    tick();
    chk("drain_hold", 32'(dut.state), 32'(DRAIN));
    cfg_en = 1'b0; rx_if.rx_data = 8'h77; rx_if.rx_done = 1'b1;
    tick();
    rx_if.rx_done = 1'b0; rx_if.rx_busy = 1'b0;
    chk("drain_idle", 32'(dut.state), 32'(IDLE));
    chk("drain_rx_en0", 32'(rx_if.rx_en), 0);
    chk("drain_pushed", 32'(rd_data), 32'h77);
    tick();
    chk("idle_keeps_fifo", {23'd0, empty, rd_data}, 32'h077);

    // Reset mid-frame with two entries stored
    cfg_en = 1'b1; cfg_load_value = 10'h155;
    tick();
    chk("rearm_load", 32'(rx_if.load_value), 32'h155);
    tick();
    rx_if.rx_data = 8'h88; rx_if.rx_done = 1'b1;
    tick();
    rx_if.rx_done = 1'b1; rx_if.rx_err = 1'b1;
    tick();
    rx_if.rx_done = 1'b0; rx_if.rx_err = 1'b0;
    tick();
    chk("pre_rst_flags", {30'd0, frame_err, empty}, 32'b10);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    chk("arst_flags", {29'd0, overrun, frame_err, irq}, 0);
    chk("arst_ctrl", {30'd0, rx_if.rx_en, rx_if.rx_rst}, 0);
    cfg_en = 1'b0; rx_if.rx_data = 8'h99; rx_if.rx_done = 1'b1;
    #2 arst_n = 1'b1;
    tick(); tick();
    rx_if.rx_done = 1'b0;
    chk("post_rst_no_push", 32'(empty), 1);
    chk("post_rst_idle", 32'(dut.state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
